// File: rtl/dsec_host_ctrl_if.sv
// Host <-> dsec bus: key/data presentation toward dsec and result return from dsec.
// The host side uses the master modport; a dsec model or the block itself uses slave.
interface dsec_host_ctrl_if;
    logic [63:0] dsec_data_in;
    logic        dsec_key_config;
    logic        dsec_in_valid;
    logic        dsec_rdy;
    logic [63:0] dsec_data_out;
    logic        dsec_error;
    logic        dsec_out_valid;
    logic        dsec_out_rcvd;

    modport master (
        output dsec_data_in,
        output dsec_key_config,
        output dsec_in_valid,
        output dsec_out_rcvd,
        input  dsec_rdy,
        input  dsec_data_out,
        input  dsec_error,
        input  dsec_out_valid
    );

    modport slave (
        input  dsec_data_in,
        input  dsec_key_config,
        input  dsec_in_valid,
        input  dsec_out_rcvd,
        output dsec_rdy,
        output dsec_data_out,
        output dsec_error,
        output dsec_out_valid
    );
endinterface

// File: rtl/dsec_host_ctrl.sv
// Host controller for dsec: loads the three 3DES keys, streams plaintext words and
// buffers results in a small FIFO. Define DSEC_HOST_ERR_DROP_EN to drop error words.
module dsec_host_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_keys,
    input  logic [63:0]      key_a,
    input  logic [63:0]      key_b,
    input  logic [63:0]      key_c,
    input  logic [63:0]      src_data,
    input  logic             src_valid,
    output logic             src_ready,
    dsec_host_ctrl_if.master dsec,
    output logic [63:0]      snk_data,
    output logic             snk_error,
    output logic             snk_valid,
    input  logic             snk_ready,
    output logic             keys_loaded,
    output logic             timeout,
    output logic [7:0]       err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [TW-1:0] STALL_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] STALL_HIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, KEY1, KEY2, KEY3, STREAM} state_t;

    state_t        state;
    logic [63:0]   hold_data;
    logic          hold_valid;
    logic          key_config_q;
    logic          out_rcvd_q;
    logic          rekey_pending;
    logic [63:0]   key_a_q;
    logic [63:0]   key_b_q;
    logic [63:0]   key_c_q;
    logic [TW-1:0] stall_cnt;

    logic xfer;
    logic src_accept;

    assign xfer       = hold_valid && dsec.dsec_rdy;
    assign src_ready  = (state == STREAM) && !rekey_pending && (!hold_valid || dsec.dsec_rdy);
    assign src_accept = src_valid && src_ready;

    assign dsec.dsec_data_in    = hold_data;
    assign dsec.dsec_in_valid   = hold_valid;
    assign dsec.dsec_key_config = key_config_q;
    assign dsec.dsec_out_rcvd   = out_rcvd_q;

    // Input side: key sequencing, data streaming and the stall watchdog.
    // A re-key request in STREAM waits for the pending data word to leave first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            key_config_q  <= 1'b0;
            rekey_pending <= 1'b0;
            key_a_q       <= '0;
            key_b_q       <= '0;
            key_c_q       <= '0;
            keys_loaded   <= 1'b0;
            timeout       <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_keys) begin
                        key_a_q      <= key_a;
                        key_b_q      <= key_b;
                        key_c_q      <= key_c;
                        hold_data    <= key_a;
                        hold_valid   <= 1'b1;
                        key_config_q <= 1'b1;
                        state        <= KEY1;
                    end
                end
                KEY1: begin
                    if (xfer) begin
                        hold_data <= key_b_q;
                        state     <= KEY2;
                    end
                end
                KEY2: begin
                    if (xfer) begin
                        hold_data <= key_c_q;
                        state     <= KEY3;
                    end
                end
                KEY3: begin
                    if (xfer) begin
                        hold_valid   <= 1'b0;
                        key_config_q <= 1'b0;
                        keys_loaded  <= 1'b1;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (rekey_pending) begin
                        if (!hold_valid || xfer) begin
                            hold_data     <= key_a_q;
                            hold_valid    <= 1'b1;
                            key_config_q  <= 1'b1;
                            rekey_pending <= 1'b0;
                            state         <= KEY1;
                        end
                    end else begin
                        if (src_accept) begin
                            hold_data  <= src_data;
                            hold_valid <= 1'b1;
                        end else if (xfer) begin
                            hold_valid <= 1'b0;
                        end
                        if (start_keys) begin
                            key_a_q       <= key_a;
                            key_b_q       <= key_b;
                            key_c_q       <= key_c;
                            rekey_pending <= 1'b1;
                            keys_loaded   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (!hold_valid || dsec.dsec_rdy) begin
                stall_cnt <= '0;
            end else begin
                if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + TW'(1);
                if (stall_cnt == STALL_HIT) timeout <= 1'b1;
            end

            if (state == STREAM && !rekey_pending && start_keys) begin
                timeout   <= 1'b0;
                stall_cnt <= '0;
            end
        end
    end

    // Result capture: the acknowledge cycle itself blocks capture, so dsec sees
    // exactly one out_rcvd pulse per result and throughput tops out at one per 2 cycles.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        cap_ok;
    logic        push;
    logic        pop;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !fifo_empty && snk_ready;

`ifdef DSEC_HOST_ERR_DROP_EN
    logic [63:0] mem [FIFO_DEPTH];
    logic [63:0] head;
    logic [63:0] wdata;

    assign cap_ok    = dsec.dsec_out_valid && !out_rcvd_q && (dsec.dsec_error || !fifo_full);
    assign push      = cap_ok && !dsec.dsec_error;
    assign wdata     = dsec.dsec_data_out;
    assign head      = mem[rptr[AW-1:0]];
    assign snk_data  = fifo_empty ? 64'd0 : head;
    assign snk_error = 1'b0;
`else
    logic [64:0] mem [FIFO_DEPTH];
    logic [64:0] head;
    logic [64:0] wdata;

    assign cap_ok    = dsec.dsec_out_valid && !out_rcvd_q && !fifo_full;
    assign push      = cap_ok;
    assign wdata     = {dsec.dsec_error, dsec.dsec_data_out};
    assign head      = mem[rptr[AW-1:0]];
    assign snk_data  = fifo_empty ? 64'd0 : head[63:0];
    assign snk_error = fifo_empty ? 1'b0 : head[64];
`endif

    assign snk_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            out_rcvd_q <= 1'b0;
            err_count  <= '0;
        end else begin
            out_rcvd_q <= cap_ok;
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            if (cap_ok && dsec.dsec_error && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
